// File: rtl/ps2_rx_scanq_pkg.sv
// Shared constants, FSM state type and parity helper for the PS/2 scan-code receiver.
package ps2_rx_scanq_pkg;

   // Prefix bytes folded into flags on the following code
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam logic [7:0] PS2_EXT = 8'hE0;

   // Queue entry layout: {ext, brk, code[7:0]}
   localparam int unsigned ENTRY_W = 10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } ps2_state_e;

   // Odd parity holds when data plus parity bit carry an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
      return ^{code, par};
   endfunction

endpackage

// File: rtl/ps2_rx_scanq_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Head entry is read combinationally and
// forced to zero while empty so the outputs are clean after reset.
module ps2_rx_scanq_sync_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A simultaneous pop frees the slot, so a push into a full queue still lands
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because dout is gated by empty
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/ps2_rx_scanq.sv
// PS/2 keyboard receiver: synchronise, deframe, check, fold F0/E0 prefixes, queue codes.
module ps2_rx_scanq
   import ps2_rx_scanq_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_code,
   output logic       out_brk,
   output logic       out_ext,
   output logic       overflow,
   output logic       err_parity,
   output logic       err_frame,
   input  logic       clr_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC - 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   fall;
   logic                   data_s;

   ps2_state_e             state;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   par_bit;
   logic [TW-1:0]          timer;
   logic                   brk_pend;
   logic                   ext_pend;
   logic                   push_q;
   logic [ENTRY_W-1:0]     push_data;

   logic [ENTRY_W-1:0]     head;
   logic                   empty;
   logic                   full;
   logic                   pop;

   // Synchronisers and edge history; reset to 1 so the idle line shows no edge
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // Frame FSM with timeout, prefix folding and the parity/frame sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         timer      <= '0;
         brk_pend   <= 1'b0;
         ext_pend   <= 1'b0;
         push_q     <= 1'b0;
         push_data  <= '0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         push_q <= 1'b0;
         // Clear first so a set event later in this block wins
         if (clr_err) begin
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
         end
         if (fall) begin
            timer <= '0;
            case (state)
               S_IDLE: begin
                  // A high start bit is treated as a glitch and ignored
                  if (!data_s) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end
               end
               S_DATA: begin
                  shreg   <= {data_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= S_PARITY;
               end
               S_PARITY: begin
                  par_bit <= data_s;
                  state   <= S_STOP;
               end
               S_STOP: begin
                  state <= S_IDLE;
                  if (!data_s) begin
                     err_frame <= 1'b1;
                  end else if (!odd_parity_ok(shreg, par_bit)) begin
                     err_parity <= 1'b1;
                     brk_pend   <= 1'b0;
                     ext_pend   <= 1'b0;
                  end else if (shreg == PS2_BRK) begin
                     brk_pend <= 1'b1;
                  end else if (shreg == PS2_EXT) begin
                     ext_pend <= 1'b1;
                  end else begin
                     push_q    <= 1'b1;
                     push_data <= {ext_pend, brk_pend, shreg};
                     brk_pend  <= 1'b0;
                     ext_pend  <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end else if (state != S_IDLE) begin
            if (timer == TIMER_MAX) begin
               state     <= S_IDLE;
               timer     <= '0;
               err_frame <= 1'b1;
               brk_pend  <= 1'b0;
               ext_pend  <= 1'b0;
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

   assign pop = out_valid & out_ready;

   // Overflow: a push is lost only when full and not relieved by a same-cycle pop
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         if (clr_err) overflow <= 1'b0;
         if (push_q && full && !pop) overflow <= 1'b1;
      end
   end

   ps2_rx_scanq_sync_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push_q),
      .din  (push_data),
      .pop  (pop),
      .dout (head),
      .empty(empty),
      .full (full)
   );

   assign out_valid = ~empty;
   assign out_ext   = head[9];
   assign out_brk   = head[8];
   assign out_code  = head[7:0];

endmodule

// File: tb/tb_ps2_rx_scanq.sv
// Directed plus randomized bench for ps2_rx_scanq against a queue-based reference model.
module tb_ps2_rx_scanq;

   localparam int DEPTH = 4;
   localparam int TO    = 300;
   localparam int HALF  = 10;
   localparam int GAP   = 30;
   localparam logic [7:0] BRK = 8'hF0;
   localparam logic [7:0] EXT = 8'hE0;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_code;
   logic       out_brk;
   logic       out_ext;
   logic       overflow;
   logic       err_parity;
   logic       err_frame;
   logic       clr_err;

   int total = 0;
   int bad   = 0;

   // Reference model state: expected queue of {ext, brk, code} and flags
   logic [9:0] mq[$];
   bit         m_brk, m_ext, m_ovf, m_par, m_frm;

   ps2_rx_scanq #(
      .FIFO_DEPTH (DEPTH),
      .SYNC_STAGES(2),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_brk   (out_brk),
      .out_ext   (out_ext),
      .overflow  (overflow),
      .err_parity(err_parity),
      .err_frame (err_frame),
      .clr_err   (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply the receiver's rules to one complete frame
   task automatic model_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
      if (bad_stop) begin
         m_frm = 1;
      end else if (bad_par) begin
         m_par = 1;
         m_brk = 0;
         m_ext = 0;
      end else if (code == BRK) begin
         m_brk = 1;
      end else if (code == EXT) begin
         m_ext = 1;
      end else begin
         if (mq.size() == DEPTH) m_ovf = 1;
         else mq.push_back({m_ext, m_brk, code});
         m_brk = 0;
         m_ext = 0;
      end
   endtask

   // mode 0: plain; 1: check push latency; 2: pop the head in the cycle the push lands
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits, input int mode);
      logic [10:0] fr;
      fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_data = fr[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10 && mode == 1) begin
            repeat (3) @(negedge clk);
            check("latency_before", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("latency_at", 32'(out_valid), 32'd1);
            repeat (HALF - 4) @(negedge clk);
         end else if (i == 10 && mode == 2) begin
            repeat (3) @(negedge clk);
            check("pushpop_head", 32'({out_ext, out_brk, out_code}), 32'(mq[0]));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            void'(mq.pop_front());
            repeat (HALF - 4) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      repeat (GAP) @(negedge clk);
      if (nbits == 11) model_frame(code, bad_par, bad_stop);
   endtask

   task automatic send(input logic [7:0] code);
      send_frame(code, 1'b0, 1'b0, 11, 0);
   endtask

   task automatic check_flags(input string tag);
      check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, "_err_parity"}, 32'(err_parity), 32'(m_par));
      check({tag, "_err_frame"}, 32'(err_frame), 32'(m_frm));
   endtask

   task automatic clear_flags();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
      m_ovf = 0;
      m_par = 0;
      m_frm = 0;
   endtask

   // Pop every expected entry, comparing the head before each pop
   task automatic drain(input string tag);
      int n;
      n = mq.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_entry"}, 32'({out_ext, out_brk, out_code}), 32'(mq[0]));
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         void'(mq.pop_front());
      end
      check({tag, "_empty"}, 32'(out_valid), 32'd0);
   endtask

   task automatic do_reset();
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rst      = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      mq.delete();
      m_brk = 0; m_ext = 0; m_ovf = 0; m_par = 0; m_frm = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, 32'({out_valid, out_code, out_brk, out_ext}), 32'd0);
      check({tag, "_flags"}, 32'({overflow, err_parity, err_frame}), 32'd0);
   endtask

   initial begin
      logic [7:0] code;
      int         r;
      bit         bp, bs;

      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
      do_reset();
      check_all_zero("reset");

      // Plain make code, with push latency and hold-while-not-ready
      send_frame(8'h1C, 1'b0, 1'b0, 11, 1);
      check_flags("t1");
      repeat (3) @(negedge clk);
      check("t1_hold", 32'({out_valid, out_ext, out_brk, out_code}), 32'({1'b1, mq[0]}));
      drain("t1");

      // Break prefix folds into the next code
      send(BRK);
      check("t2_no_prefix_entry", 32'(out_valid), 32'd0);
      send(8'h1C);
      drain("t2");

      // Extended + break, then plain
      send(EXT); send(BRK); send(8'h75);
      drain("t3a");
      send(8'h75);
      drain("t3b");

      // Parity error, clear, good frame; parity error also drops a pending prefix
      send_frame(8'h1B, 1'b1, 1'b0, 11, 0);
      check("t4_no_entry", 32'(out_valid), 32'd0);
      check_flags("t4_err");
      clear_flags();
      check_flags("t4_clr");
      send(8'h1B);
      drain("t4");
      send(BRK);
      send_frame(8'h33, 1'b1, 1'b0, 11, 0);
      send(8'h1C);
      check_flags("t4_pend");
      clear_flags();
      drain("t4_pend");

      // Bad stop bit
      send_frame(8'h22, 1'b0, 1'b1, 11, 0);
      check_flags("t4_stop");
      clear_flags();

      // Overflow with ready low, then push+pop while full
      send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
      check_flags("t5_ovf");
      clear_flags();
      send_frame(8'h3C, 1'b0, 1'b0, 11, 2);
      check_flags("t5_pushpop");
      drain("t5");

      // Mid-frame timeout clears pending prefix and recovers
      send(BRK);
      send_frame(8'h5A, 1'b0, 1'b0, 5, 0);
      repeat (TO + 20) @(negedge clk);
      m_frm = 1; m_brk = 0; m_ext = 0;
      check_flags("t6_timeout");
      clear_flags();
      send(8'h1C);
      drain("t6");

      // Reset mid-frame with entries queued and a flag set
      send(8'h12); send(8'h13);
      send_frame(8'h44, 1'b1, 1'b0, 11, 0);
      send_frame(8'h66, 1'b0, 1'b0, 6, 0);
      do_reset();
      @(negedge clk);
      check_all_zero("t6_rst");
      send(8'h1C);
      drain("t6_rst");

      // Randomized traffic
      for (int k = 0; k < 30; k++) begin
         r = $urandom_range(0, 9);
         code = (r < 2) ? BRK : (r < 4) ? EXT : 8'($urandom_range(0, 255));
         bp = ($urandom_range(0, 7) == 0);
         bs = ($urandom_range(0, 11) == 0);
         send_frame(code, bp, bs, 11, 0);
         check_flags("rnd");
         if (m_par || m_frm || m_ovf) clear_flags();
         if (mq.size() >= 3) drain("rnd");
      end
      drain("rnd_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
